serial_comb_stage: RTL and testbench
====================================

Name: serial_comb_stage

Overview:
- Bit-serial comb (differentiator) stage; the subtracting counterpart to the bit-serial integrator adder.
- Computes y[n] = x[n] - x[n-DELAY] modulo 2^WORDWIDTH.
- Uses one full-adder cell, LSB first, with inverted subtrahend and carry-in = 1.
- Sits after the integrator/decimator chain of the serial CIC; valid/ready handshake on both sides.

Parameters:
- WORDWIDTH, 8, operand/result width in bits (>= 2).
- DELAY, 1, differential delay M in words; legal 1..4; other values are an elaboration error.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  data_in is valid this cycle.
- in_ready  output  1  block accepts a word this cycle; registered.
- data_in  input  WORDWIDTH  new sample x[n].
- hist_clr  input  1  synchronous clear of the delay history; honoured only in IDLE.
- out_valid  output  1  out_data, borrow and ovf are valid; registered.
- out_ready  input  1  downstream accepts the result this cycle.
- out_data  output  WORDWIDTH  y[n], two's complement wrap.
- borrow  output  1  unsigned borrow: 1 when x[n] < x[n-DELAY].
- ovf  output  1  signed overflow of the subtraction.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, borrow=0, ovf=0.
  - Bit counter=0; carry=0; all DELAY history words=0.
  - Reset overrides everything, including mid-SHIFT and HOLD; any partial result is discarded.
- State machine:
  - IDLE: in_ready=1.
    - If in_valid && !hist_clr: accept (edge E0). Load A=data_in and B=hist[DELAY-1]; shift history (hist[k]<=hist[k-1], hist[0]<=data_in); carry<=1; counter<=0; in_ready<=0; go to SHIFT.
    - If hist_clr: history<=0, no accept that edge, stay IDLE.
  - SHIFT: one bit per edge, edges E1..EW.
    - Bit i: d = A[0] ^ ~B[0] ^ carry; carry <= majority(A[0], ~B[0], carry).
    - Shift A and B right by one; d enters the result shift register MSB, shifting right.
    - On the edge where counter==WORDWIDTH-1: register out_data from the full result, borrow=~carry_out, ovf=(A_msb != B_msb) && (d_msb != A_msb) using the original MSBs; out_valid<=1; go to HOLD.
  - HOLD: out_valid=1; outputs stable.
    - On an edge with out_ready=1: out_valid<=0, in_ready<=1, go to IDLE.
- Latency and throughput:
  - out_valid is first high after edge EW (WORDWIDTH edges after the accept edge).
  - With out_ready tied high, sustained throughput is one word per WORDWIDTH+2 cycles.
- Boundary conditions:
  - in_valid and hist_clr are ignored outside IDLE; in_ready is 0 there.
  - out_ready while out_valid=0 has no effect.
  - Backpressure holds outputs indefinitely; the history is not advanced until the next accept.
  - hist_clr and in_valid together in IDLE: clear wins, the word is not accepted, in_ready stays 1.
  - First DELAY outputs after reset or clear subtract 0.
  - Result wraps modulo 2^WORDWIDTH; no saturation.

Test Plan:
- Reset, WORDWIDTH=8, DELAY=1, out_ready=1, input 0x05 -> after 8 edges out_valid=1, out_data=0x05, borrow=0, ovf=0; in_ready high 2 cycles later.
- Inputs 0x05 then 0x03 -> second result out_data=0xFE, borrow=1, ovf=0.
- Inputs 0x01 then 0x80 -> second result out_data=0x7F, borrow=0, ovf=1.
- Backpressure: out_ready=0 for 5 cycles during HOLD with in_valid=1, data_in=0x22 -> out_data stable, in_ready=0; 0x22 accepted only after the out_ready edge, result 0x22 minus previous word.
- DELAY=2: inputs 10, 20, 30, 45 -> outputs 10, 20, 20, 25; then hist_clr in IDLE, input 7 -> output 7.
- rst_n low for one edge 4 cycles into SHIFT -> out_valid=0, in_ready=1, history 0; next input 0x09 -> out_data=0x09, borrow=0.

Source files
------------

// File: rtl/serial_comb_stage_if.sv
// Handshake bundle for the bit-serial comb stage: word in on the upstream side, difference out downstream.
interface serial_comb_stage_if #(
  parameter int WORDWIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WORDWIDTH-1:0] data_in;
  logic                 hist_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [WORDWIDTH-1:0] out_data;
  logic                 borrow;
  logic                 ovf;

  modport master (
    output in_valid, data_in, hist_clr, out_ready,
    input  in_ready, out_valid, out_data, borrow, ovf
  );

  modport slave (
    input  in_valid, data_in, hist_clr, out_ready,
    output in_ready, out_valid, out_data, borrow, ovf
  );
endinterface

// File: rtl/serial_comb_stage.sv
// Bit-serial comb stage: y[n] = x[n] - x[n-DELAY] mod 2^WORDWIDTH, one full-adder cell, LSB first.
module serial_comb_stage #(
  parameter int WORDWIDTH = 8,
  parameter int DELAY     = 1
) (
  input logic                clk,
  input logic                rst_n,
  serial_comb_stage_if.slave bus
);

  if (WORDWIDTH < 2 || DELAY < 1 || DELAY > 4) begin : g_bad_param
    $error("serial_comb_stage: WORDWIDTH must be >= 2 and DELAY in 1..4");
  end

  localparam int             CNT_W    = $clog2(WORDWIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORDWIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t               state_q, state_d;
  logic [WORDWIDTH-1:0] hist_q [DELAY];
  logic [WORDWIDTH-1:0] a_p0, b_p0, res_p0;
  logic                 carry_p0, a_msb_p0, b_msb_p0;
  logic [CNT_W-1:0]     cnt_p0;
  logic [WORDWIDTH-1:0] out_data_p1;
  logic                 borrow_p1, ovf_p1;

  logic                 sum_bit, cout_bit, last_bit;
  logic [WORDWIDTH-1:0] res_shift;

  // Subtraction as A + ~B + 1: carry is preset to 1 on accept, B inverted per bit
  assign sum_bit   = fa_sum(a_p0[0], ~b_p0[0], carry_p0);
  assign cout_bit  = fa_carry(a_p0[0], ~b_p0[0], carry_p0);
  assign res_shift = {sum_bit, res_p0[WORDWIDTH-1:1]};
  assign last_bit  = (cnt_p0 == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid && !bus.hist_clr) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == HOLD);
  end

  assign bus.out_data = out_data_p1;
  assign bus.borrow   = borrow_p1;
  assign bus.ovf      = ovf_p1;

  // Stage p0: operand load and serial shift; stage p1: word-wide result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_p0        <= '0;
      b_p0        <= '0;
      res_p0      <= '0;
      carry_p0    <= 1'b0;
      a_msb_p0    <= 1'b0;
      b_msb_p0    <= 1'b0;
      cnt_p0      <= '0;
      out_data_p1 <= '0;
      borrow_p1   <= 1'b0;
      ovf_p1      <= 1'b0;
      for (int k = 0; k < DELAY; k++) hist_q[k] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.hist_clr) begin
            for (int k = 0; k < DELAY; k++) hist_q[k] <= '0;
          end else if (bus.in_valid) begin
            a_p0     <= bus.data_in;
            b_p0     <= hist_q[DELAY-1];
            a_msb_p0 <= bus.data_in[WORDWIDTH-1];
            b_msb_p0 <= hist_q[DELAY-1][WORDWIDTH-1];
            carry_p0 <= 1'b1;
            cnt_p0   <= '0;
            hist_q[0] <= bus.data_in;
            for (int k = 1; k < DELAY; k++) hist_q[k] <= hist_q[k-1];
          end
        end
        SHIFT: begin
          a_p0     <= a_p0 >> 1;
          b_p0     <= b_p0 >> 1;
          res_p0   <= res_shift;
          carry_p0 <= cout_bit;
          cnt_p0   <= cnt_p0 + 1'b1;
          if (last_bit) begin
            out_data_p1 <= res_shift;
            borrow_p1   <= ~cout_bit;
            ovf_p1      <= (a_msb_p0 != b_msb_p0) && (sum_bit != a_msb_p0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comb_stage.sv
// Directed bench for serial_comb_stage: a DELAY=1 and a DELAY=2 instance sharing one clock.
module tb_serial_comb_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid, hist_clr, out_ready;
  logic [7:0] data_in;
  int         sel;
  int         n_checks = 0;
  int         n_err    = 0;

  serial_comb_stage_if #(.WORDWIDTH(8)) if1 ();
  serial_comb_stage_if #(.WORDWIDTH(8)) if2 ();

  serial_comb_stage #(.WORDWIDTH(8), .DELAY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1.slave)
  );

  serial_comb_stage #(.WORDWIDTH(8), .DELAY(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if2.slave)
  );

  assign if1.in_valid  = in_valid && (sel == 0);
  assign if1.hist_clr  = hist_clr && (sel == 0);
  assign if1.data_in   = data_in;
  assign if1.out_ready = out_ready;
  assign if2.in_valid  = in_valid && (sel == 1);
  assign if2.hist_clr  = hist_clr && (sel == 1);
  assign if2.data_in   = data_in;
  assign if2.out_ready = out_ready;

  logic       o_valid, o_ready, o_borrow, o_ovf;
  logic [7:0] o_data;
  assign o_valid  = (sel == 0) ? if1.out_valid : if2.out_valid;
  assign o_ready  = (sel == 0) ? if1.in_ready  : if2.in_ready;
  assign o_borrow = (sel == 0) ? if1.borrow    : if2.borrow;
  assign o_ovf    = (sel == 0) ? if1.ovf       : if2.ovf;
  assign o_data   = (sel == 0) ? if1.out_data  : if2.out_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!o_valid && n < 40) begin
      step();
      n++;
    end
  endtask

  // Accepts x, expects the result WORDWIDTH edges later, then releases it with out_ready=1.
  task automatic send(input string tag, input logic [7:0] x, input logic [7:0] exp_d,
                      input logic exp_b, input logic exp_o);
    int n;
    n = 0;
    while (!o_ready && n < 40) begin
      step();
      n++;
    end
    check({tag, "_rdy_before"}, o_ready, 1);
    in_valid = 1'b1;
    data_in  = x;
    step();
    in_valid = 1'b0;
    check({tag, "_busy"}, o_ready, 0);
    wait_valid(n);
    check({tag, "_latency"}, n, 8);
    check({tag, "_data"}, o_data, exp_d);
    check({tag, "_borrow"}, o_borrow, exp_b);
    check({tag, "_ovf"}, o_ovf, exp_o);
    check({tag, "_rdy_hold"}, o_ready, 0);
    step();
    check({tag, "_valid_drop"}, o_valid, 0);
    check({tag, "_rdy_after"}, o_ready, 1);
  endtask

  initial begin
    int n;
    sel       = 0;
    in_valid  = 1'b0;
    hist_clr  = 1'b0;
    out_ready = 1'b1;
    data_in   = '0;
    rst_n     = 1'b0;
    step();
    step();

    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check("rst_valid", o_valid, 0);
      check("rst_ready", o_ready, 1);
      check("rst_data", o_data, 0);
      check("rst_borrow", o_borrow, 0);
      check("rst_ovf", o_ovf, 0);
    end
    sel   = 0;
    rst_n = 1'b1;
    #1;

    // DELAY=1: basic, borrow, overflow
    send("d1_w05", 8'h05, 8'h05, 1'b0, 1'b0);
    send("d1_w03", 8'h03, 8'hFE, 1'b1, 1'b0);
    send("d1_w01", 8'h01, 8'hFE, 1'b1, 1'b0);
    send("d1_w80", 8'h80, 8'h7F, 1'b0, 1'b1);

    // Backpressure: 0x40 - 0x80 held while 0x22 waits upstream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = 8'h40;
    step();
    in_valid  = 1'b0;
    wait_valid(n);
    check("bp_latency", n, 8);
    check("bp_data", o_data, 8'hC0);
    check("bp_borrow", o_borrow, 1);
    check("bp_ovf", o_ovf, 1);
    in_valid = 1'b1;
    data_in  = 8'h22;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", o_valid, 1);
      check("bp_hold_data", o_data, 8'hC0);
      check("bp_hold_ready", o_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", o_valid, 0);
    check("bp_release_ready", o_ready, 1);
    step();
    in_valid = 1'b0;
    check("bp_accept_busy", o_ready, 0);
    wait_valid(n);
    check("bp2_latency", n, 8);
    check("bp2_data", o_data, 8'hE2);
    check("bp2_borrow", o_borrow, 1);
    check("bp2_ovf", o_ovf, 0);
    step();
    check("bp2_ready", o_ready, 1);

    // Reset in the middle of SHIFT discards the word and the history
    in_valid = 1'b1;
    data_in  = 8'h55;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    check("midrst_data", o_data, 0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("midrst_idle_valid", o_valid, 0);
    end
    send("midrst_w09", 8'h09, 8'h09, 1'b0, 1'b0);

    // DELAY=2 instance
    sel = 1;
    #1;
    send("d2_w10", 8'd10, 8'd10, 1'b0, 1'b0);
    send("d2_w20", 8'd20, 8'd20, 1'b0, 1'b0);
    send("d2_w30", 8'd30, 8'd20, 1'b0, 1'b0);
    send("d2_w45", 8'd45, 8'd25, 1'b0, 1'b0);

    hist_clr = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'd99;
    step();
    hist_clr = 1'b0;
    in_valid = 1'b0;
    check("clr_ready", o_ready, 1);
    step();
    check("clr_no_accept", o_valid, 0);
    check("clr_ready2", o_ready, 1);
    send("d2_w7", 8'd7, 8'd7, 1'b0, 1'b0);
    send("d2_w3", 8'd3, 8'd3, 1'b0, 1'b0);
    send("d2_w12", 8'd12, 8'd5, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
